// File: rtl/mips_data_bus_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : mips_data_bus_bridge
//  Description : Converts the CPU's single-cycle data-port accesses into
//                word-wide Avalon-MM transfers with waitrequest. The CPU is
//                frozen through cpu_clock_enable while a transfer is
//                outstanding and is released for exactly one completing cycle.
//                A stuck slave is aborted after TIMEOUT_CYCLES wait cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module mips_data_bus_bridge #(
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERROR_DATA     = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        reset,
    // CPU data port
    input  logic [31:0] cpu_data_address,
    input  logic        cpu_data_read,
    input  logic        cpu_data_write,
    input  logic [31:0] cpu_data_writedata,
    output logic [31:0] cpu_data_readdata,
    output logic        cpu_clock_enable,
    // Avalon-MM host
    output logic [31:0] avm_address,
    output logic        avm_read,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    output logic [3:0]  avm_byteenable,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    // Status
    output logic        bus_error
);

    // Counter is at least one bit wide so a disabled timeout still elaborates.
    localparam int              CNT_W       = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit              C_TO_EN     = (TIMEOUT_CYCLES > 0);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
    localparam logic [CNT_W-1:0] C_CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [31:0]      r_address;
    logic [31:0]      r_writedata;
    logic             r_read;
    logic             r_write;
    logic [31:0]      r_readdata;
    logic             r_bus_error;
    logic [CNT_W-1:0] r_wait_cnt;

    logic             w_req;
    logic             w_start;
    logic             w_complete;
    logic             w_timeout;

    // Byte lanes are resolved inside the CPU, so the low address bits carry
    // no information for the bus.
    logic             w_unused_addr_bits;
    assign w_unused_addr_bits = &{1'b0, cpu_data_address[1:0]};

    assign w_req      = cpu_data_read | cpu_data_write;
    assign w_start    = (r_state == ST_IDLE) && w_req;
    assign w_complete = (r_state == ST_REQ) && !avm_waitrequest;
    // The abort fires on the wait cycle that would bring the count to
    // TIMEOUT_CYCLES, so the strobe is visible for exactly that many cycles.
    assign w_timeout  = C_TO_EN && (r_state == ST_REQ) && avm_waitrequest
                        && (r_wait_cnt == C_CNT_LAST);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: IDLE -> REQ on a request, REQ -> DONE on completion
    // or abort, DONE always returns to IDLE (requests seen there belong to
    // the instruction that is committing).
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    w_state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                if (w_complete || w_timeout) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Bus request, captured read data and the sticky error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_address   <= 32'h0;
            r_writedata <= 32'h0;
            r_read      <= 1'b0;
            r_write     <= 1'b0;
            r_readdata  <= 32'h0;
            r_bus_error <= 1'b0;
        end else if (w_start) begin
            r_address   <= {cpu_data_address[31:2], 2'b00};
            r_writedata <= cpu_data_writedata;
            // A simultaneous read and write is treated as a store.
            r_write     <= cpu_data_write;
            r_read      <= cpu_data_read & ~cpu_data_write;
        end else if (w_complete) begin
            r_read  <= 1'b0;
            r_write <= 1'b0;
            if (r_read) begin
                r_readdata <= avm_readdata;
            end
        end else if (w_timeout) begin
            r_read      <= 1'b0;
            r_write     <= 1'b0;
            r_bus_error <= 1'b1;
            if (r_read) begin
                r_readdata <= ERROR_DATA;
            end
        end
    end

    // Stall counter: counts wait cycles within one transfer, saturates
    // instead of wrapping, and restarts whenever REQ is left.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wait_cnt <= '0;
        end else if (w_state_next != ST_REQ) begin
            r_wait_cnt <= '0;
        end else if ((r_state == ST_REQ) && avm_waitrequest && (r_wait_cnt != C_CNT_MAX)) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    // The CPU runs during reset (to clear its registers), when idle with no
    // access pending, and in the single completing cycle.
    assign cpu_clock_enable = reset
                              | ((r_state == ST_IDLE) & ~w_req)
                              | (r_state == ST_DONE);

    assign cpu_data_readdata = r_readdata;
    assign avm_address       = r_address;
    assign avm_read          = r_read;
    assign avm_write         = r_write;
    assign avm_writedata     = r_writedata;
    assign avm_byteenable    = 4'hF;
    assign bus_error         = r_bus_error;

endmodule
`default_nettype wire
